axistream_ingest: RTL

- Active AXI-Stream slave that receives packets and writes them word-by-word into the filter's packet memory. It is the receiving-end counterpart of the forwarder.
- Unlike the passive snooper, it owns TREADY and back-pressures the upstream source whenever no packet buffer is available.
- Reports each completed packet to packet memory with a 1-cycle done pulse, a word count and a truncation flag.

---
 rtl/axistream_ingest.sv | 134 +++++++++++++
 1 files changed

// File: rtl/axistream_ingest.sv
// axistream_ingest
// Active AXI-Stream slave that writes received packets word-by-word into a
// packet buffer and reports each completed packet with a one-cycle done pulse.
// It drives TREADY and holds it low whenever no buffer is available.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   TDATA/TVALID/TLAST  inbound stream
//   TREADY              stream ready (registered)
//   wr_addr/wr_data/wr_en  packet-memory write port (registered)
//   mem_ready           a packet buffer is free; sampled only while idle
//   done/len/truncated  packet-complete pulse with word count and overflow flag
//
// state | meaning
// IDLE  | no buffer claimed, TREADY=0, waiting for mem_ready
// RECV  | TREADY=1, each accepted beat is written at the current count
// DRAIN | buffer full, TREADY=1, beats discarded until TLAST
// DONE  | TREADY=0, last write lands, done/len/truncated issued next
module axistream_ingest #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] TDATA,
  input  logic                  TVALID,
  output logic                  TREADY,
  input  logic                  TLAST,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  input  logic                  mem_ready,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   len,
  output logic                  truncated
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t                  state_q;
  logic [ADDR_WIDTH:0]     count_q;
  logic [ADDR_WIDTH:0]     count_d;
  logic                    trunc_q;
  logic                    tready_q;
  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    done_q;
  logic [ADDR_WIDTH:0]     len_q;
  logic                    truncated_q;
  logic                    accept;

  assign accept  = TVALID & tready_q;
  assign count_d = count_q + (ADDR_WIDTH+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      trunc_q     <= 1'b0;
      tready_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      len_q       <= '0;
      truncated_q <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      len_q       <= '0;
      truncated_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Holding off during the done pulse keeps TREADY low for at least
          // three cycles between packets.
          if (mem_ready && !done_q) begin
            state_q  <= S_RECV;
            tready_q <= 1'b1;
          end
        end
        S_RECV: begin
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= count_q[ADDR_WIDTH-1:0];
            wr_data_q <= TDATA;
            count_q   <= count_d;
            if (TLAST) begin
              state_q  <= S_DONE;
              tready_q <= 1'b0;
            end else if (count_q == LAST_IDX) begin
              state_q <= S_DRAIN;
              trunc_q <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (accept && TLAST) begin
            state_q  <= S_DONE;
            tready_q <= 1'b0;
          end
        end
        S_DONE: begin
          done_q      <= 1'b1;
          len_q       <= count_q;
          truncated_q <= trunc_q;
          count_q     <= '0;
          trunc_q     <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          tready_q <= 1'b0;
        end
      endcase
    end
  end

  assign TREADY    = tready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign len       = len_q;
  assign truncated = truncated_q;

endmodule
